// File: rtl/ps2_rx_frame_if.sv
// Purpose: byte-FIFO read port and status pulses of the PS/2 receive front end.
// Latency: none; this is only a bundle of wires.
// Backpressure: the consumer pops with rd_en; nothing else ever stalls.
`timescale 1ns/1ps
interface ps2_rx_frame_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;
  logic          busy;

  // Receiver side: owns the FIFO and the status outputs
  modport master (
    input  rd_en,
    output rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow, busy
  );

  // Consumer side, e.g. the register block that pops bytes
  modport slave (
    output rd_en,
    input  rx_data, rx_valid, fifo_count, parity_err, frame_err, overflow, busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// Purpose: sync + de-glitch raw PS/2 lines, deframe 11-bit frames, buffer good bytes.
// Latency: byte visible one cycle after the STOP-bit strobe; error pulses likewise.
// Backpressure: none towards the device; a full FIFO drops the byte and pulses overflow.
`timescale 1ns/1ps
module ps2_rx_frame #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_rx_frame_if.master        rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt, filt_prev;
  logic [FW-1:0]          filt_cnt;
  logic                   fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   parity_err_q, frame_err_q, busy_q;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   overflow_q;
  logic                   push, pop, full, wr_en;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Two-flop (or longer) synchronisers; lines idle high
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Filtered clock only follows after FILTER_LEN consecutive differing samples
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt;
      if (clk_s != filt) begin
        if (filt_cnt == FILT_LAST) begin
          filt     <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Strobe is high in the cycle right after the filtered clock drops
  assign fall = filt_prev & ~filt;

  // Good frame: stop bit high and odd parity over data+parity
  always_comb begin
    push = 1'b0;
    if (fall && state == STOP && data_s && ((^shreg) ^ par_bit))
      push = 1'b1;
  end

  // Deframing FSM with inactivity timeout; all outputs registered
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !data_s) begin
          state   <= DATA;
          bit_cnt <= '0;
          shreg   <= '0;
          busy_q  <= 1'b1;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shreg[bit_cnt] <= data_s;
            if (bit_cnt == 3'd7) state <= PARITY;
            else                 bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (!data_s)                    frame_err_q  <= 1'b1;
            else if (!((^shreg) ^ par_bit)) parity_err_q <= 1'b1;
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        frame_err_q <= 1'b1;
        state       <= IDLE;
        busy_q      <= 1'b0;
        to_cnt      <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign pop   = rx.rd_en && (count != '0);
  assign full  = (count == FULL_CNT);
  // When full, a simultaneous pop frees the head slot the write lands in
  assign wr_en = push && (!full || pop);

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

  // Storage array, no reset needed since reads are gated by rx_valid
  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  assign rx.rx_valid   = (count != '0);
  assign rx.rx_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign rx.fifo_count = count;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.overflow   = overflow_q;
  assign rx.busy       = busy_q;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Purpose: directed self-checking bench for the PS/2 receive front end.
// Latency: checks sampled 1 time unit after the ACLK rising edge.
// Backpressure: exercises FIFO full, overflow and push-with-pop.
`timescale 1ns/1ps
module tb_ps2_rx_frame;
  localparam int TO = 2000;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic ps2_clk, ps2_data;
  int   n_cmp = 0, n_err = 0;
  int   n_pe = 0, n_fe = 0, n_ov = 0;

  ps2_rx_frame_if #(.FIFO_DEPTH(16)) rx_if ();

  ps2_rx_frame #(
    .SYNC_STAGES(2), .FILTER_LEN(8), .TIMEOUT_CYC(TO), .FIFO_DEPTH(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx(rx_if.master)
  );

  always #5 ACLK = ~ACLK;

  // Pulse counters, sampled on the falling edge
  always @(negedge ACLK) begin
    if (rx_if.parity_err) n_pe++;
    if (rx_if.frame_err)  n_fe++;
    if (rx_if.overflow)   n_ov++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic clr_pulses();
    n_pe = 0; n_fe = 0; n_ov = 0;
  endtask

  // One bit: data set while clk high, clk low 20 cycles, high again.
  // With pop set, rd_en is raised in the cycle of the falling-edge strobe.
  task automatic send_bit(input logic b, input logic pop);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    if (pop) begin
      tick(10);
      rx_if.rd_en = 1'b1;
      tick(1);
      rx_if.rd_en = 1'b0;
      tick(9);
    end else begin
      tick(20);
    end
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n, input logic pop_last);
    for (int i = 0; i < n; i++) send_bit(fr[i], pop_last && (i == n - 1));
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic pop_at_stop);
    send_bits({stp, par, b, 1'b0}, 11, pop_at_stop);
  endtask

  task automatic pop1();
    rx_if.rd_en = 1'b1;
    tick(1);
    rx_if.rd_en = 1'b0;
  endtask

  initial begin
    ARESETN     = 1'b0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    rx_if.rd_en = 1'b0;
    tick(5);
    ARESETN = 1'b1;
    tick(5);

    // Reset state
    chk("rst_valid", rx_if.rx_valid, 0);
    chk("rst_data",  rx_if.rx_data, 0);
    chk("rst_count", rx_if.fifo_count, 0);
    chk("rst_busy",  rx_if.busy, 0);
    chk("rst_pulses", n_pe + n_fe + n_ov, 0);

    // 1: good frame 0x1C, parity 0
    clr_pulses();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", rx_if.rx_valid, 1);
    chk("t1_data",  rx_if.rx_data, 8'h1C);
    chk("t1_count", rx_if.fifo_count, 1);
    chk("t1_errs",  n_pe + n_fe + n_ov, 0);
    pop1();
    chk("t1_popped", rx_if.fifo_count, 0);

    // 2: bad parity, then bad stop bit
    clr_pulses();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("t2_pe", n_pe, 1);
    chk("t2_pe_fe", n_fe, 0);
    chk("t2_pe_count", rx_if.fifo_count, 0);
    clr_pulses();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t2_fe", n_fe, 1);
    chk("t2_fe_pe", n_pe, 0);
    chk("t2_fe_count", rx_if.fifo_count, 0);

    // 3: timeout after 5 data bits, then frame 0xF0
    clr_pulses();
    send_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 6, 1'b0);
    chk("t3_busy_mid", rx_if.busy, 1);
    tick(TO + 50);
    chk("t3_fe", n_fe, 1);
    chk("t3_busy", rx_if.busy, 0);
    chk("t3_count0", rx_if.fifo_count, 0);
    clr_pulses();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    chk("t3_data",  rx_if.rx_data, 8'hF0);
    chk("t3_count", rx_if.fifo_count, 1);
    chk("t3_errs",  n_pe + n_fe + n_ov, 0);
    pop1();

    // 4: 17 frames into a 16-deep FIFO
    clr_pulses();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    chk("t4_count", rx_if.fifo_count, 16);
    chk("t4_ov", n_ov, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", rx_if.rx_data, i);
      pop1();
    end
    chk("t4_empty", rx_if.rx_valid, 0);
    chk("t4_count0", rx_if.fifo_count, 0);

    // 5: full FIFO, pop in the same cycle as a push
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(8'h20 + i);
      send_frame(b, ~^b, 1'b1, 1'b0);
    end
    chk("t5_full", rx_if.fifo_count, 16);
    clr_pulses();
    send_frame(8'h30, ~^8'h30, 1'b1, 1'b1);
    chk("t5_count", rx_if.fifo_count, 16);
    chk("t5_ov", n_ov, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t5_order", rx_if.rx_data, 32'h21 + i);
      pop1();
    end
    chk("t5_empty", rx_if.rx_valid, 0);

    // 6a: 3-cycle low glitch with data low must not start a frame
    clr_pulses();
    ps2_data = 1'b0;
    tick(5);
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    chk("t6_glitch_busy", rx_if.busy, 0);
    ps2_data = 1'b1;
    tick(20);
    chk("t6_glitch_errs", n_pe + n_fe + n_ov, 0);

    // 6b: reset in the middle of a frame clears FIFO and FSM at once
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t6_pre_count", rx_if.fifo_count, 1);
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5, 1'b0);
    chk("t6_pre_busy", rx_if.busy, 1);
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_busy",  rx_if.busy, 0);
    chk("t6_rst_valid", rx_if.rx_valid, 0);
    chk("t6_rst_count", rx_if.fifo_count, 0);
    chk("t6_rst_data",  rx_if.rx_data, 0);
    tick(3);
    ARESETN = 1'b1;
    tick(5);
    clr_pulses();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("t6_data",  rx_if.rx_data, 8'h5A);
    chk("t6_count", rx_if.fifo_count, 1);
    chk("t6_errs",  n_pe + n_fe + n_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
